framebuffer_arbiter: RTL and testbench



---
 rtl/framebuffer_arbiter_pkg.sv | 7 +
 rtl/framebuffer_arbiter_if.sv | 26 ++
 rtl/framebuffer_arbiter_sync_fifo.sv | 37 +++
 rtl/framebuffer_arbiter.sv | 71 +++++++
 tb/tb_framebuffer_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/framebuffer_arbiter_pkg.sv
// framebuffer_arbiter_pkg: shared widths, SRAM read latency and arbiter state type
package framebuffer_arbiter_pkg;
  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 18;
  localparam int DEF_READ_LATENCY = 4;
  typedef enum logic {READ_PRI, FORCE_WR} arb_state_t;
endpackage

// File: rtl/framebuffer_arbiter_if.sv
// framebuffer_arbiter_if: capture/display handshakes and SRAM command port
interface framebuffer_arbiter_if import framebuffer_arbiter_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic wr_valid, wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic rd_req_valid, rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic rd_resp_valid;
  logic [DATA_W-1:0] rd_resp_data;
  logic sram_read_enable, sram_write_enable;
  logic [ADDR_W-1:0] sram_r_addr, sram_w_addr;
  logic [DATA_W-1:0] sram_data_in, sram_data_out;
  modport master (
    output wr_valid, wr_addr, wr_data, rd_req_valid, rd_req_addr, sram_data_out,
    input wr_ready, rd_req_ready, rd_resp_valid, rd_resp_data,
    input sram_read_enable, sram_write_enable, sram_r_addr, sram_w_addr, sram_data_in
  );
  modport slave (
    input wr_valid, wr_addr, wr_data, rd_req_valid, rd_req_addr, sram_data_out,
    output wr_ready, rd_req_ready, rd_resp_valid, rd_resp_data,
    output sram_read_enable, sram_write_enable, sram_r_addr, sram_w_addr, sram_data_in
  );
endinterface

// File: rtl/framebuffer_arbiter_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO, synchronous reset, full/empty flags
module sync_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rptr];
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wptr] <= din;
      wptr <= wptr + AW'(do_push);
      rptr <= rptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter: read-priority SRAM port arbiter with buffered writes.
// Define FRAMEBUFFER_ARBITER_STARVE_GUARD_EN to enable the write starvation guard.
module framebuffer_arbiter import framebuffer_arbiter_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int WFIFO_DEPTH = 16,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int STARVE_LIMIT = 8
) (
  input logic clk,
  input logic reset,
  framebuffer_arbiter_if.slave bus
);
  logic [ADDR_W+DATA_W-1:0] wf_dout;
  logic wf_full, wf_empty, rd_grant, wr_issue;
  logic [READ_LATENCY-1:0] vld;
  assign bus.wr_ready = !reset && !wf_full;
  assign rd_grant = bus.rd_req_valid && bus.rd_req_ready;
  sync_fifo #(.WIDTH(ADDR_W+DATA_W), .DEPTH(WFIFO_DEPTH)) u_wfifo (
    .clk(clk), .reset(reset),
    .push(bus.wr_valid && bus.wr_ready), .din({bus.wr_addr, bus.wr_data}),
    .pop(wr_issue), .dout(wf_dout), .full(wf_full), .empty(wf_empty)
  );
`ifdef FRAMEBUFFER_ARBITER_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  arb_state_t state;
  logic [CW-1:0] cnt;
  logic at_limit;
  assign at_limit = cnt == CW'(STARVE_LIMIT - 1);
  assign bus.rd_req_ready = !reset && state == READ_PRI;
  assign wr_issue = !wf_empty && (state == FORCE_WR || !bus.rd_req_valid);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= READ_PRI;
      cnt <= '0;
    end else if (state == FORCE_WR) begin
      state <= READ_PRI;
      cnt <= '0;
    end else if (wf_empty || wr_issue) begin
      cnt <= '0;
    end else if (rd_grant) begin
      state <= at_limit ? FORCE_WR : READ_PRI;
      cnt <= at_limit ? '0 : cnt + 1'b1;
    end
  end
`else
  assign bus.rd_req_ready = !reset;
  assign wr_issue = !wf_empty && !bus.rd_req_valid;
`endif
  // valid bits track issued reads so responses align to the fixed SRAM latency
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.sram_read_enable <= 1'b0;
      bus.sram_write_enable <= 1'b0;
      bus.sram_r_addr <= '0;
      bus.sram_w_addr <= '0;
      bus.sram_data_in <= '0;
      bus.rd_resp_valid <= 1'b0;
      bus.rd_resp_data <= '0;
      vld <= '0;
    end else begin
      bus.sram_read_enable <= rd_grant;
      bus.sram_write_enable <= wr_issue;
      if (rd_grant) bus.sram_r_addr <= bus.rd_req_addr;
      if (wr_issue) {bus.sram_w_addr, bus.sram_data_in} <= wf_dout;
      vld <= READ_LATENCY'({vld, bus.sram_read_enable});
      bus.rd_resp_valid <= vld[READ_LATENCY-1];
      if (vld[READ_LATENCY-1]) bus.rd_resp_data <= bus.sram_data_out;
    end
  end
endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb_framebuffer_arbiter: randomized and directed bench with a mock SRAM and memory model
module tb_framebuffer_arbiter;
  import framebuffer_arbiter_pkg::*;
  localparam int AW = 20, DW = 18, DEPTH = 16, RL = 4, LIMIT = 8;
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cmp = 0, bad = 0;
  framebuffer_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  framebuffer_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WFIFO_DEPTH(DEPTH), .READ_LATENCY(RL),
    .STARVE_LIMIT(LIMIT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return DW'(a) ^ 18'h15A5A;
  endfunction

  // mock SRAM: data appears RL cycles after the command cycle, X when no read
  logic [DW-1:0] sram_mem [logic [AW-1:0]];
  logic [DW-1:0] pipe [RL];
  always @(posedge clk) begin
    if (bus.sram_write_enable) sram_mem[bus.sram_w_addr] = bus.sram_data_in;
    pipe[0] <= !bus.sram_read_enable ? 'x :
      sram_mem.exists(bus.sram_r_addr) ? sram_mem[bus.sram_r_addr] : dflt(bus.sram_r_addr);
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.sram_data_out = pipe[RL-1];

  // reference model: pushes, grants, issued commands and responses all in order
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  wr_t wq[$];
  logic [AW-1:0] rq[$];
  logic [DW-1:0] respq[$];
  always @(negedge clk) begin
    wr_t w;
    logic [AW-1:0] a;
    logic [DW-1:0] e;
    if (reset) begin
      wq.delete();
      rq.delete();
      respq.delete();
    end else begin
      cmp++;
      if (bus.sram_read_enable && bus.sram_write_enable) begin
        bad++;
        $display("FAIL both_enables: read_enable=%b write_enable=%b, required not both", bus.sram_read_enable, bus.sram_write_enable);
      end
      if (bus.sram_write_enable) begin
        cmp++;
        if (wq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: addr=%h data=%h, no pending push", bus.sram_w_addr, bus.sram_data_in);
        end else begin
          w = wq.pop_front();
          model_mem[w.a] = w.d;
          if ({bus.sram_w_addr, bus.sram_data_in} !== w) begin
            bad++;
            $display("FAIL write_order: got %h/%h, required %h/%h", bus.sram_w_addr, bus.sram_data_in, w.a, w.d);
          end
        end
      end
      if (bus.sram_read_enable) begin
        cmp++;
        if (rq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_read: addr=%h, no pending grant", bus.sram_r_addr);
        end else begin
          a = rq.pop_front();
          respq.push_back(model_mem.exists(a) ? model_mem[a] : dflt(a));
          if (bus.sram_r_addr !== a) begin
            bad++;
            $display("FAIL read_addr: got %h, required %h", bus.sram_r_addr, a);
          end
        end
      end
      if (bus.rd_resp_valid) begin
        cmp++;
        if (respq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_resp: data=%h, no read outstanding", bus.rd_resp_data);
        end else begin
          e = respq.pop_front();
          if (bus.rd_resp_data !== e) begin
            bad++;
            $display("FAIL resp_data: got %h, required %h", bus.rd_resp_data, e);
          end
        end
      end
      if (bus.wr_valid && bus.wr_ready) wq.push_back('{bus.wr_addr, bus.wr_data});
      if (bus.rd_req_valid && bus.rd_req_ready) rq.push_back(bus.rd_req_addr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_valid = 1'b0;
    bus.rd_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    idle_inputs();
    while ((wq.size() || rq.size() || respq.size()) && n < 300) begin
      step();
      n++;
    end
    repeat (2) step();
    cmp++;
    if (wq.size() || rq.size() || respq.size()) begin
      bad++;
      $display("FAIL drain: pending writes=%0d reads=%0d resps=%0d, required 0", wq.size(), rq.size(), respq.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    cmp++;
    if ({bus.wr_ready, bus.rd_req_ready, bus.rd_resp_valid, bus.sram_read_enable, bus.sram_write_enable} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: wr_ready/rd_req_ready/resp_valid/re/we=%b, required 00000",
        {bus.wr_ready, bus.rd_req_ready, bus.rd_resp_valid, bus.sram_read_enable, bus.sram_write_enable});
    end
    cmp++;
    if ({bus.rd_resp_data, bus.sram_r_addr, bus.sram_w_addr, bus.sram_data_in} !== '0) begin
      bad++;
      $display("FAIL reset_data: resp=%h raddr=%h waddr=%h din=%h, required 0", bus.rd_resp_data, bus.sram_r_addr, bus.sram_w_addr, bus.sram_data_in);
    end
    reset = 1'b0;
    #1;
    cmp++;
    if ({bus.wr_ready, bus.rd_req_ready} !== 2'b11) begin
      bad++;
      $display("FAIL post_reset_ready: wr_ready/rd_req_ready=%b, required 11", {bus.wr_ready, bus.rd_req_ready});
    end
  endtask

  task automatic test_read();
    sram_mem[20'h00010] = 18'h2ABCD;
    model_mem[20'h00010] = 18'h2ABCD;
    bus.rd_req_addr = 20'h00010;
    bus.rd_req_valid = 1'b1;
    cmp++;
    if (bus.rd_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL read_ready: got %b, required 1", bus.rd_req_ready);
    end
    step();
    bus.rd_req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      cmp++;
      if (bus.rd_resp_valid !== (k == RL + 1)) begin
        bad++;
        $display("FAIL read_latency: cycle %0d after accept valid=%b, required %b", k + 1, bus.rd_resp_valid, k == RL + 1);
      end
      if (k == RL + 1) begin
        cmp++;
        if (bus.rd_resp_data !== 18'h2ABCD) begin
          bad++;
          $display("FAIL read_data: got %h, required 2abcd", bus.rd_resp_data);
        end
      end
    end
  endtask

  task automatic test_fill();
    int pushed = 0;
    bit rdy;
    bus.rd_req_addr = AW'($urandom_range(0, 15));
    bus.rd_req_valid = 1'b1;
    bus.wr_addr = AW'($urandom_range(0, 15));
    bus.wr_data = DW'($urandom);
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 64 && bus.wr_ready; i++) begin
      rdy = bus.wr_ready;
      step();
      if (rdy) begin
        pushed++;
        bus.wr_addr = AW'($urandom_range(0, 15));
        bus.wr_data = DW'($urandom);
      end
    end
    idle_inputs();
    cmp++;
`ifdef FRAMEBUFFER_ARBITER_STARVE_GUARD_EN
    if (pushed < DEPTH || bus.wr_ready !== 1'b0) begin
`else
    if (pushed != DEPTH || bus.wr_ready !== 1'b0) begin
`endif
      bad++;
      $display("FAIL fill_count: pushed=%0d wr_ready=%b, required %0d pushes then wr_ready=0", pushed, bus.wr_ready, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step();
      cmp++;
      if (bus.sram_write_enable !== 1'b1) begin
        bad++;
        $display("FAIL drain_consecutive: write %0d write_enable=%b, required 1", i, bus.sram_write_enable);
      end
      if (i == 0) begin
        cmp++;
        if (bus.wr_ready !== 1'b1) begin
          bad++;
          $display("FAIL ready_after_pop: wr_ready=%b, required 1", bus.wr_ready);
        end
      end
    end
    step();
    cmp++;
    if (bus.sram_write_enable !== 1'b0) begin
      bad++;
      $display("FAIL drain_extra: write_enable=%b after %0d writes, required 0", bus.sram_write_enable, DEPTH);
    end
    drain();
  endtask

  task automatic test_starve();
    bus.rd_req_addr = AW'($urandom_range(0, 15));
    bus.rd_req_valid = 1'b1;
    bus.wr_addr = AW'($urandom_range(0, 15));
    bus.wr_data = DW'($urandom);
    bus.wr_valid = 1'b1;
    step();
    bus.wr_valid = 1'b0;
`ifdef FRAMEBUFFER_ARBITER_STARVE_GUARD_EN
    for (int i = 0; i < LIMIT; i++) begin
      cmp++;
      if (bus.rd_req_ready !== 1'b1 || bus.sram_write_enable !== 1'b0) begin
        bad++;
        $display("FAIL starve_grant: grant %0d ready=%b we=%b, required 1/0", i, bus.rd_req_ready, bus.sram_write_enable);
      end
      step();
    end
    cmp++;
    if (bus.rd_req_ready !== 1'b0) begin
      bad++;
      $display("FAIL starve_force: rd_req_ready=%b, required 0", bus.rd_req_ready);
    end
    step();
    cmp++;
    if (bus.sram_write_enable !== 1'b1 || bus.rd_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL starve_write: we=%b ready=%b, required 1/1", bus.sram_write_enable, bus.rd_req_ready);
    end
`else
    for (int i = 0; i < 20; i++) begin
      cmp++;
      if (bus.rd_req_ready !== 1'b1 || bus.sram_write_enable !== 1'b0) begin
        bad++;
        $display("FAIL strict_priority: cycle %0d ready=%b we=%b, required 1/0", i, bus.rd_req_ready, bus.sram_write_enable);
      end
      step();
    end
    bus.rd_req_valid = 1'b0;
    step();
    cmp++;
    if (bus.sram_write_enable !== 1'b1) begin
      bad++;
      $display("FAIL strict_write: we=%b in first read-free cycle, required 1", bus.sram_write_enable);
    end
`endif
    drain();
  endtask

  task automatic test_reset_mid();
    bus.rd_req_valid = 1'b1;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.rd_req_addr = AW'($urandom_range(0, 15));
      bus.wr_addr = AW'($urandom_range(0, 15));
      bus.wr_data = DW'($urandom);
      if (i == 2) bus.wr_valid = 1'b0;
      step();
    end
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    cmp++;
    if ({bus.sram_read_enable, bus.sram_write_enable, bus.wr_ready, bus.rd_req_ready} !== 4'b0011) begin
      bad++;
      $display("FAIL reset_mid_first: re/we/wr_ready/rd_req_ready=%b, required 0011",
        {bus.sram_read_enable, bus.sram_write_enable, bus.wr_ready, bus.rd_req_ready});
    end
    for (int i = 0; i < RL + 6; i++) begin
      step();
      cmp++;
      if (bus.rd_resp_valid !== 1'b0 || bus.sram_write_enable !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_discard: cycle %0d resp_valid=%b we=%b, required 0/0", i, bus.rd_resp_valid, bus.sram_write_enable);
      end
    end
  endtask

  task automatic test_random();
    bit wacc, racc;
    for (int i = 0; i < 600; i++) begin
      wacc = bus.wr_valid && bus.wr_ready;
      racc = bus.rd_req_valid && bus.rd_req_ready;
      if (!bus.wr_valid || wacc) begin
        bus.wr_valid = $urandom_range(0, 1) == 1;
        bus.wr_addr = AW'($urandom_range(0, 15));
        bus.wr_data = DW'($urandom);
      end
      if (!bus.rd_req_valid || racc) begin
        bus.rd_req_valid = $urandom_range(0, 2) != 0;
        bus.rd_req_addr = AW'($urandom_range(0, 15));
      end
      step();
    end
    drain();
  endtask

  initial begin
    idle_inputs();
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_req_addr = '0;
    test_reset();
    test_read();
    test_fill();
    test_starve();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
